// File: rtl/psram_cmd_scheduler_pkg.sv
// Shared types and constants for the PSRAM command scheduler.
package psram_cmd_scheduler_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_cmd_e;

  // Tcmd for burst-16 on the Gowin PSRAM HS controller.
  localparam int PSRAM_TCMD_BURST16 = 14;

  // Counter/index width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psram_cmd_scheduler_sched_tag_fifo.sv
// Read tag FIFO: remembers which master issued each outstanding read burst.
// Push while full is honoured only when a pop happens in the same cycle.
module sched_tag_fifo
  import psram_cmd_scheduler_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Tag storage, no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psram_cmd_scheduler.sv
// N-master round-robin command scheduler in front of the PSRAM HS controller.
// Optional statistics counters: define PSRAM_SCHED_STATS_EN.
//
// Write window FSM:
//   state    | meaning
//   WR_IDLE  | no write burst in progress, new commands may issue
//   WR_BURST | forwarding the remaining write beats of the accepted writer
module psram_cmd_scheduler
  import psram_cmd_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 21,
  parameter int DATA_W          = 64,
  parameter int MASK_W          = 8,
  parameter int CMD_GAP         = PSRAM_TCMD_BURST16,
  parameter int WR_BEATS        = 4,
  parameter int RD_BEATS        = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RD_DRAIN        = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          calib,
  input  logic [NUM_MASTERS-1:0]        m_cmd_en,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  input  logic [NUM_MASTERS*MASK_W-1:0] m_data_mask,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic [NUM_MASTERS-1:0]        m_rd_data_valid,
  output logic                          mem_cmd_en,
  output logic                          mem_cmd,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  output logic [MASK_W-1:0]             mem_data_mask,
  input  logic [DATA_W-1:0]             mem_rd_data,
  input  logic                          mem_rd_data_valid,
  output logic                          rd_orphan
`ifdef PSRAM_SCHED_STATS_EN
  ,
  output logic [NUM_MASTERS*16-1:0]     stat_cmds,
  output logic [NUM_MASTERS*16-1:0]     stat_stall
`endif
);

  localparam int PTR_W = cnt_w(NUM_MASTERS);
  localparam int GAP_W = cnt_w(CMD_GAP);
  localparam int WB_W  = cnt_w(WR_BEATS);
  localparam int RB_W  = cnt_w(RD_BEATS);
  localparam int DR_W  = cnt_w(RD_DRAIN + 1);

  typedef enum logic {WR_IDLE, WR_BURST} wr_state_e;

  wr_state_e        wr_state, wr_state_nxt;
  logic [GAP_W-1:0] gap;
  logic [WB_W-1:0]  wr_left;
  logic [PTR_W-1:0] rr_ptr, win, cand, wr_idx, head_tag;
  logic [RB_W-1:0]  beat_cnt;
  logic [DR_W-1:0]  drain;
  logic             can_issue, accept;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, rd_live;

  // A returning beat is live only once the drain window is over and a tag waits.
  assign rd_live   = mem_rd_data_valid && (drain == '0) && !fifo_empty;
  assign fifo_pop  = rd_live && (beat_cnt == RB_W'(RD_BEATS - 1));
  assign fifo_push = accept && (mem_cmd_e'(m_cmd[win]) == MEM_READ);

  // Round-robin pick; reads are skipped while the tag FIFO cannot take them.
  always_comb begin
    can_issue = calib && (gap == '0) && (wr_state == WR_IDLE);
    accept    = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (m_cmd_en[cand] &&
          (mem_cmd_e'(m_cmd[cand]) == MEM_WRITE || !fifo_full || fifo_pop)) begin
        accept = 1'b1;
        win    = cand;
      end
    end
    accept  = accept && can_issue;
    m_ready = accept ? (NUM_MASTERS'(1) << win) : '0;
  end

  // Write window next state.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE:  if (accept && m_cmd[win] && (WR_BEATS > 1)) wr_state_nxt = WR_BURST;
      WR_BURST: if (wr_left == WB_W'(1)) wr_state_nxt = WR_IDLE;
      default:  wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write window state register.
  always_ff @(posedge clk) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_state_nxt;
  end

  // Command issue: register the winner, arm the gap timer, advance the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cmd_en    <= 1'b0;
      mem_cmd       <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      mem_data_mask <= '0;
      gap           <= '0;
      rr_ptr        <= '0;
      wr_idx        <= '0;
      wr_left       <= '0;
    end else begin
      mem_cmd_en <= accept;
      if (accept) begin
        mem_cmd       <= m_cmd[win];
        mem_addr      <= m_addr[win*ADDR_W +: ADDR_W];
        mem_wr_data   <= m_wr_data[win*DATA_W +: DATA_W];
        mem_data_mask <= m_data_mask[win*MASK_W +: MASK_W];
        gap           <= GAP_W'(CMD_GAP - 1);
        rr_ptr        <= (win == PTR_W'(NUM_MASTERS - 1)) ? '0 : win + PTR_W'(1);
        wr_idx        <= win;
        wr_left       <= m_cmd[win] ? WB_W'(WR_BEATS - 1) : '0;
      end else begin
        if (gap != '0) gap <= gap - GAP_W'(1);
        if (wr_state == WR_BURST) begin
          mem_wr_data   <= m_wr_data[wr_idx*DATA_W +: DATA_W];
          mem_data_mask <= m_data_mask[wr_idx*MASK_W +: MASK_W];
          wr_left       <= wr_left - WB_W'(1);
        end
      end
    end
  end

  // Read return: drain after reset, route beats to the head tag, flag orphans.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain           <= DR_W'(RD_DRAIN);
      beat_cnt        <= '0;
      m_rd_data       <= '0;
      m_rd_data_valid <= '0;
      rd_orphan       <= 1'b0;
    end else begin
      if (drain != '0) drain <= drain - DR_W'(1);
      m_rd_data_valid <= '0;
      if (rd_live) begin
        m_rd_data       <= mem_rd_data;
        m_rd_data_valid <= NUM_MASTERS'(1) << head_tag;
        beat_cnt        <= fifo_pop ? '0 : beat_cnt + RB_W'(1);
      end
      if (mem_rd_data_valid && (drain == '0) && fifo_empty) rd_orphan <= 1'b1;
    end
  end

  sched_tag_fifo #(
    .W     (PTR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (win),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef PSRAM_SCHED_STATS_EN
  logic [15:0] cmds_q  [NUM_MASTERS];
  logic [15:0] stall_q [NUM_MASTERS];

  // Saturating per-master accept and stall counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (reset) begin
        cmds_q[i]  <= '0;
        stall_q[i] <= '0;
      end else begin
        if (m_cmd_en[i] && m_ready[i] && cmds_q[i] != 16'hFFFF)
          cmds_q[i] <= cmds_q[i] + 16'd1;
        if (m_cmd_en[i] && !m_ready[i] && stall_q[i] != 16'hFFFF)
          stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stat
    assign stat_cmds[g*16 +: 16]  = cmds_q[g];
    assign stat_stall[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// Scoreboard bench for psram_cmd_scheduler with two masters and default timing.
module tb_psram_cmd_scheduler;

  localparam int N   = 2;
  localparam int AW  = 21;
  localparam int DW  = 64;
  localparam int MW  = 8;
  localparam int GAP = 14;
  localparam int WRB = 4;
  localparam int RDB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            calib;
  logic [N-1:0]    m_cmd_en;
  logic [N-1:0]    m_cmd;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wr_data;
  logic [N*MW-1:0] m_data_mask;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   m_rd_data;
  logic [N-1:0]    m_rd_data_valid;
  logic            mem_cmd_en;
  logic            mem_cmd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [MW-1:0]   mem_data_mask;
  logic [DW-1:0]   mem_rd_data;
  logic            mem_rd_data_valid;
  logic            rd_orphan;
`ifdef PSRAM_SCHED_STATS_EN
  logic [N*16-1:0] stat_cmds;
  logic [N*16-1:0] stat_stall;
`endif

  always #5 clk = ~clk;

  psram_cmd_scheduler #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .CMD_GAP(GAP),
    .WR_BEATS(WRB), .RD_BEATS(RDB), .MAX_OUTSTANDING(2), .RD_DRAIN(32)
  ) dut (
    .clk(clk), .reset(reset), .calib(calib),
    .m_cmd_en(m_cmd_en), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_data_mask(m_data_mask), .m_ready(m_ready),
    .m_rd_data(m_rd_data), .m_rd_data_valid(m_rd_data_valid),
    .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
    .rd_orphan(rd_orphan)
`ifdef PSRAM_SCHED_STATS_EN
    , .stat_cmds(stat_cmds), .stat_stall(stat_stall)
`endif
  );

  typedef struct { int m; bit wr; logic [AW-1:0] a; int acc; } cmd_t;
  typedef struct { int m; logic [DW-1:0] d; int cyc; } rd_t;

  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  int   cmd_cyc[$];
  int   grant_log[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [DW-1:0] pat(input int m, input logic [AW-1:0] a, input int k);
    return {8'(8'hD0 + m), 27'h0, a, 8'(k)};
  endfunction

  function automatic logic [MW-1:0] mask_of(input int m);
    return 8'(8'h5A ^ m);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops command and read-beat expectations as the DUT produces them.
  int   wb_left = 0;
  int   wm = 0;
  int   wk = 0;
  logic [AW-1:0] wa = '0;
  cmd_t ce;
  rd_t  re;
  always @(negedge clk) begin
    if (wb_left > 0) begin
      total++;
      if (mem_wr_data !== pat(wm, wa, wk) || mem_data_mask !== mask_of(wm)) begin
        bad++;
        $display("FAIL wr_beat%0d actual=%h/%h required=%h/%h", wk, mem_wr_data,
                 mem_data_mask, pat(wm, wa, wk), mask_of(wm));
      end
      wk++;
      wb_left--;
    end
    if (mem_cmd_en === 1'b1) begin
      cmd_cyc.push_back(cyc);
      total++;
      if (exp_cmd.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd actual=addr %h required=no command", mem_addr);
      end else begin
        ce = exp_cmd.pop_front();
        if (mem_cmd !== ce.wr || mem_addr !== ce.a || cyc != ce.acc) begin
          bad++;
          $display("FAIL cmd_issue actual=cmd %0b addr %h cyc %0d required=cmd %0b addr %h cyc %0d",
                   mem_cmd, mem_addr, cyc, ce.wr, ce.a, ce.acc);
        end
        if (ce.wr) begin
          total++;
          if (mem_wr_data !== pat(ce.m, ce.a, 0) || mem_data_mask !== mask_of(ce.m)) begin
            bad++;
            $display("FAIL wr_beat0 actual=%h/%h required=%h/%h", mem_wr_data, mem_data_mask,
                     pat(ce.m, ce.a, 0), mask_of(ce.m));
          end
          wb_left = WRB - 1;
          wm = ce.m;
          wa = ce.a;
          wk = 1;
        end
      end
    end
    if (m_rd_data_valid !== '0) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rd actual=valid %b data %h required=no beat", m_rd_data_valid, m_rd_data);
      end else begin
        re = exp_rd.pop_front();
        if (m_rd_data_valid !== (N'(1) << re.m) || m_rd_data !== re.d || cyc != re.cyc) begin
          bad++;
          $display("FAIL rd_beat actual=valid %b data %h cyc %0d required=valid %b data %h cyc %0d",
                   m_rd_data_valid, m_rd_data, cyc, N'(1) << re.m, re.d, re.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int post);
    @(negedge clk);
    reset = 1'b1; calib = 1'b1;
    m_cmd_en = '0; m_cmd = '0; m_addr = '0; m_wr_data = '0; m_data_mask = '0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmd_cyc.delete();
    grant_log.delete();
    repeat (post) @(negedge clk);
  endtask

  // Master model: raise request, wait for m_ready, then present write beats.
  task automatic master_cmd(input int m, input bit wr, input logic [AW-1:0] a,
                            input int budget, output int acc, output int waited);
    bit ok = 1'b0;
    waited = 0;
    acc = -1;
    @(negedge clk);
    m_cmd[m] = wr;
    m_addr[m*AW +: AW] = a;
    m_wr_data[m*DW +: DW] = pat(m, a, 0);
    m_data_mask[m*MW +: MW] = mask_of(m);
    m_cmd_en[m] = 1'b1;
    #1;
    while (!ok && waited < budget) begin
      if (m_ready[m] === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
        waited++;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=no ready for m%0d required=ready within %0d", m, budget);
      m_cmd_en[m] = 1'b0;
    end else begin
      acc = cyc + 1;
      exp_cmd.push_back('{m, wr, a, acc});
      grant_log.push_back(m);
      @(posedge clk);
      @(negedge clk);
      m_cmd_en[m] = 1'b0;
      if (wr) begin
        for (int k = 1; k < WRB; k++) begin
          if (k > 1) @(negedge clk);
          m_wr_data[m*DW +: DW] = pat(m, a, k);
        end
      end
    end
  endtask

  // Controller model: return n read beats and expect them at master m.
  task automatic ctrl_beats(input int m, input logic [DW-1:0] base, input int n, output int last);
    last = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      mem_rd_data_valid = 1'b1;
      mem_rd_data = base + DW'(k);
      exp_rd.push_back('{m, base + DW'(k), cyc + 1});
      last = cyc + 1;
    end
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    total++;
    if (m_ready !== '0 || mem_cmd_en !== 1'b0 || mem_cmd !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl actual=%b/%b/%b required=0/0/0", m_ready, mem_cmd_en, mem_cmd);
    end
    total++;
    if (mem_addr !== '0 || mem_wr_data !== '0 || mem_data_mask !== '0) begin
      bad++;
      $display("FAIL reset_mem actual=%h/%h/%h required=0", mem_addr, mem_wr_data, mem_data_mask);
    end
    total++;
    if (m_rd_data !== '0 || m_rd_data_valid !== '0 || rd_orphan !== 1'b0) begin
      bad++;
      $display("FAIL reset_rd actual=%h/%b/%b required=0", m_rd_data, m_rd_data_valid, rd_orphan);
    end
  endtask

  task automatic test_single_write();
    int acc, wt;
    do_reset(0);
    master_cmd(0, 1'b1, 21'h000100, 20, acc, wt);
    total++;
    if (wt != 0) begin
      bad++;
      $display("FAIL single_ready_latency actual=%0d required=0", wt);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_gap();
    int a0, a1, wt;
    do_reset(0);
    master_cmd(1, 1'b1, 21'h000111, 40, a0, wt);
    master_cmd(1, 1'b1, 21'h000222, 40, a1, wt);
    repeat (6) @(negedge clk);
    total++;
    if (cmd_cyc.size() != 2) begin
      bad++;
      $display("FAIL gap_count actual=%0d required=2", cmd_cyc.size());
    end else begin
      total++;
      if (cmd_cyc[1] - cmd_cyc[0] != GAP) begin
        bad++;
        $display("FAIL gap_spacing actual=%0d required=%0d", cmd_cyc[1] - cmd_cyc[0], GAP);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset(0);
    fork
      begin
        int acc, wt;
        for (int n = 0; n < 4; n++) master_cmd(0, 1'b1, AW'(21'h010 + n), 100, acc, wt);
      end
      begin
        int acc, wt;
        for (int n = 0; n < 4; n++) master_cmd(1, 1'b1, AW'(21'h020 + n), 100, acc, wt);
      end
    join
    repeat (6) @(negedge clk);
    total++;
    if (grant_log.size() != 8) begin
      bad++;
      $display("FAIL rr_count actual=%0d required=8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (grant_log[i] != (i % 2)) begin
          bad++;
          $display("FAIL rr_order[%0d] actual=%0d required=%0d", i, grant_log[i], i % 2);
        end
      end
    end
    for (int i = 1; i < cmd_cyc.size(); i++) begin
      total++;
      if (cmd_cyc[i] - cmd_cyc[i-1] != GAP) begin
        bad++;
        $display("FAIL rr_spacing[%0d] actual=%0d required=%0d", i, cmd_cyc[i] - cmd_cyc[i-1], GAP);
      end
    end
  endtask

  task automatic test_read_routing();
    int acc, wt, last;
    do_reset(40);
    master_cmd(0, 1'b0, 21'h000200, 40, acc, wt);
    master_cmd(1, 1'b0, 21'h000300, 40, acc, wt);
    repeat (3) @(negedge clk);
    ctrl_beats(0, 64'hAAAA_0000_0000_00A0, RDB, last);
    ctrl_beats(1, 64'hBBBB_0000_0000_00B0, RDB, last);
    repeat (4) @(negedge clk);
    total++;
    if (exp_rd.size() != 0) begin
      bad++;
      $display("FAIL rd_routing_left actual=%0d required=0", exp_rd.size());
    end
  endtask

  task automatic test_full_fifo();
    int a1, a2, a3, aw, wt, b4, last;
    do_reset(40);
    master_cmd(0, 1'b0, 21'h000400, 40, a1, wt);
    master_cmd(0, 1'b0, 21'h000410, 40, a2, wt);
    b4 = -1;
    fork
      master_cmd(0, 1'b0, 21'h000420, 200, a3, wt);
      begin
        repeat (20) @(negedge clk);
        master_cmd(1, 1'b1, 21'h000500, 40, aw, wt);
      end
      begin
        repeat (40) @(negedge clk);
        ctrl_beats(0, 64'hC100_0000_0000_0000, RDB, b4);
      end
    join
    total++;
    if (a3 < b4 || a3 > b4 + 1) begin
      bad++;
      $display("FAIL full_third_accept actual=cyc %0d required=cyc %0d or %0d", a3, b4, b4 + 1);
    end
    total++;
    if (aw < 0 || aw >= b4) begin
      bad++;
      $display("FAIL full_write_bypass actual=cyc %0d required=before %0d", aw, b4);
    end
    ctrl_beats(0, 64'hC200_0000_0000_0000, RDB, last);
    ctrl_beats(0, 64'hC300_0000_0000_0000, RDB, last);
    repeat (4) @(negedge clk);
    total++;
    if (exp_rd.size() != 0) begin
      bad++;
      $display("FAIL full_rd_left actual=%0d required=0", exp_rd.size());
    end
  endtask

  task automatic test_calib();
    int acc, wt, cal_cyc;
    do_reset(0);
    calib = 1'b0;
    cal_cyc = -1;
    fork
      master_cmd(0, 1'b1, 21'h000777, 60, acc, wt);
      begin
        repeat (10) @(negedge clk);
        #2;
        total++;
        if (m_ready !== '0) begin
          bad++;
          $display("FAIL calib_block actual=%b required=00", m_ready);
        end
        @(negedge clk);
        calib = 1'b1;
        cal_cyc = cyc;
      end
    join
    total++;
    if (acc != cal_cyc + 1) begin
      bad++;
      $display("FAIL calib_release actual=cyc %0d required=cyc %0d", acc, cal_cyc + 1);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_orphan();
    do_reset(0);
    repeat (9) @(negedge clk);
    mem_rd_data = 64'h1111;
    mem_rd_data_valid = 1'b1;
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rd_orphan !== 1'b0) begin
      bad++;
      $display("FAIL orphan_drain actual=%b required=0", rd_orphan);
    end
    repeat (26) @(negedge clk);
    mem_rd_data = 64'h2222;
    mem_rd_data_valid = 1'b1;
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (rd_orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_set actual=%b required=1", rd_orphan);
    end
    repeat (10) @(negedge clk);
    total++;
    if (rd_orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_sticky actual=%b required=1", rd_orphan);
    end
    do_reset(1);
    total++;
    if (rd_orphan !== 1'b0) begin
      bad++;
      $display("FAIL orphan_clear actual=%b required=0", rd_orphan);
    end
  endtask

  initial begin
    reset = 1'b1; calib = 1'b1;
    m_cmd_en = '0; m_cmd = '0; m_addr = '0; m_wr_data = '0; m_data_mask = '0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
    test_reset();
    test_single_write();
    test_gap();
    test_round_robin();
    test_read_routing();
    test_full_fifo();
    test_calib();
    test_orphan();
    total++;
    if (exp_cmd.size() != 0) begin
      bad++;
      $display("FAIL cmd_left actual=%0d required=0", exp_cmd.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_cmd_scheduler.md
Name: psram_cmd_scheduler

Overview:
- N-master command scheduler between burst-bus masters (framebuffer, debug burst writer, future blitter/line buffers) and the Gowin PSRAM HS controller.
- Replaces the fixed 20-cycle busy flag and the two-master arbiter with:
  - a parametrised command gap;
  - round-robin grant;
  - pipelined reads, with each read burst routed back to the master that issued it.
- Sits in the top level between the masters' burst_bus_if signals and the controller's cmd/addr/data ports; runs in the controller's clk_out domain.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8)
- ADDR_W, 21, controller address width
- DATA_W, 64, data width
- MASK_W, 8, data_mask width
- CMD_GAP, 14, minimum cycles from one mem_cmd_en to the next (Tcmd, burst 16)
- WR_BEATS, 4, wr_data beats per write command (including the cmd_en cycle)
- RD_BEATS, 4, rd_data_valid beats per read burst
- MAX_OUTSTANDING, 2, read bursts in flight (tag FIFO depth, power of 2)
- RD_DRAIN, 32, cycles after reset during which mem_rd_data_valid is discarded

Ports:
- clk  in  1  controller clk_out
- reset  in  1  synchronous, active-high
- calib  in  1  controller init_calib; no command issues while low
- m_cmd_en  in  NUM_MASTERS  per-master request; held with cmd/addr until accepted
- m_cmd  in  NUM_MASTERS  1=write, 0=read
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wr_data  in  NUM_MASTERS*DATA_W  packed write data
- m_data_mask  in  NUM_MASTERS*MASK_W  packed masks
- m_ready  out  NUM_MASTERS  one-hot-or-zero accept
- m_rd_data  out  DATA_W  broadcast read data
- m_rd_data_valid  out  NUM_MASTERS  per-master read beat strobe
- mem_cmd_en, mem_cmd  out  1 each  to controller
- mem_addr  out  ADDR_W  to controller
- mem_wr_data  out  DATA_W  to controller
- mem_data_mask  out  MASK_W  to controller
- mem_rd_data  in  DATA_W  from controller
- mem_rd_data_valid  in  1  from controller
- rd_orphan  out  1  sticky: read beat arrived with empty tag FIFO

Behaviour:
- Reset values:
  - all outputs 0;
  - gap counter 0 (can issue);
  - round-robin pointer 0;
  - tag FIFO empty;
  - write window idle;
  - drain counter = RD_DRAIN.
- Handshake:
  - Accept when m_cmd_en[i] && m_ready[i].
  - m_ready may depend combinationally on m_cmd_en; m_cmd_en must not depend on m_ready.
- can_issue = calib && gap==0 && write window idle && !(tag FIFO full && requesting read).
- Grant: first requesting master at or after the pointer, in ascending wrapping order. A read request that is blocked by a full FIFO is skipped, not stalled.
- On accept:
  - mem_cmd_en pulses for one cycle.
  - mem_cmd, mem_addr and mem_data_mask are registered from the winner (1-cycle latency).
  - gap is loaded with CMD_GAP-1.
  - The pointer moves to winner+1, mod NUM_MASTERS.
- Write:
  - mem_wr_data and mem_data_mask mux the writer's m_wr_data/m_data_mask for WR_BEATS cycles, aligned with mem_cmd_en.
  - The master presents successive beats on the cycles after acceptance.
- Read:
  - The winner index is pushed to the tag FIFO on accept.
  - Each mem_rd_data_valid beat is routed to the head tag: m_rd_data registered, m_rd_data_valid[head] pulses 1 cycle later.
  - A beat counter pops the head on beat RD_BEATS and wraps to 0.
- Push and pop in the same cycle when the FIFO is full: legal, and the count is unchanged.
- mem_rd_data_valid with the FIFO empty and drain==0: the beat is dropped and rd_orphan is set; it clears only on reset.
- Drain counter: decrements each cycle to 0; while it is nonzero, all mem_rd_data_valid beats are dropped silently.
- calib falling mid-gap: the gap still counts down; no new accept until calib is high.
- Reset mid-burst: the write window is aborted and in-flight read tags are discarded.

Optional Feature:
- PSRAM_SCHED_STATS_EN defined adds ports:
  - stat_cmds out NUM_MASTERS*16: per-master accepted-command counters.
  - stat_stall out NUM_MASTERS*16: cycles with m_cmd_en high and m_ready low.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (common): typedef mem_cmd_e {MEM_READ=0, MEM_WRITE=1}; localparam PSRAM_TCMD_BURST16 = 14.
- Sub-module sched_tag_fifo: synchronous FIFO, width $clog2(NUM_MASTERS) (min 1), depth MAX_OUTSTANDING, with full/empty/push/pop.

Test Plan:
- Single master write, NUM_MASTERS=2:
  - Stimulus: master 0 write to addr 0x000100, calib high.
  - Response: m_ready[0] the same cycle; mem_cmd_en 1 cycle later with mem_addr=0x000100; 4 wr_data beats forwarded in order.
- Gap:
  - Stimulus: two back-to-back writes from master 1.
  - Response: mem_cmd_en pulses exactly 14 cycles apart.
- Round robin:
  - Stimulus: masters 0 and 1 request continuously.
  - Response: grants alternate 0,1,0,1; neither master is starved.
- Read routing:
  - Stimulus: master 0 reads, then master 1 reads; controller returns 4 beats 0xA.. and then 4 beats 0xB...
  - Response: m_rd_data_valid[0] for exactly the first 4 beats, [1] for the next 4, each 1 cycle delayed.
- Full FIFO:
  - Stimulus: 3 reads with no returns, MAX_OUTSTANDING=2.
  - Response: 3rd not accepted until the first burst's 4th beat arrives; a write from the other master is still accepted meanwhile.
- Orphan/reset:
  - Stimulus: reset, then a valid beat at cycle 10 and another at cycle 40 with the FIFO empty.
  - Response: the first beat is dropped silently; the second sets rd_orphan=1.
